z80_mem_bridge: RTL and testbench

- Downstream of the Z80 CPU wrapper. Converts the CPU's asynchronous-style memory strobes (mreq_n/rd_n/wr_n) into a single-outstanding req/ack transaction towards the DRAM/video arbiter.
- Stalls the core through its clock-enable until the access completes.
- Holds read data stable on the CPU data input, and returns floating-bus 0xFF for I/O reads.

---
 rtl/z80_mem_bridge.sv | 106 ++++++++++
 tb/tb_z80_mem_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/z80_mem_bridge.sv
// Z80 memory-strobe to single-outstanding req/ack bridge with clock-enable stall.
// Optional ROM_WP_EN: writes below 16'h4000 are dropped without a memory request.
module z80_mem_bridge #(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned ADDR_BASE = 0,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       cpu_addr,
    input  logic [7:0]        cpu_dout,
    output logic [7:0]        cpu_din,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              rd_n,
    input  logic              wr_n,
    output logic              cpu_cen,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              bus_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_RELEASE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(ADDR_BASE);
    localparam logic [15:0]       CNT_LAST = 16'(TIMEOUT - 1);

    state_t              state;
    logic [7:0]          rdata;
    logic [15:0]         cnt;
    logic                start;
    logic                wp_block;
    logic [ADDR_W-1:0]   req_addr;

    always_comb begin
        start    = (state == S_IDLE) && !mreq_n && (!rd_n || !wr_n);
        req_addr = ADDR_W'(cpu_addr) + BASE;
`ifdef ROM_WP_EN
        wp_block = !wr_n && (cpu_addr < 16'h4000);
`else
        wp_block = 1'b0;
`endif
    end

    // Stall is combinational so the core freezes in the same cycle the strobe appears.
    assign cpu_cen = !(start || (state == S_REQ));
    assign cpu_din = (!iorq_n && !rd_n && mreq_n) ? 8'hFF : rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= 8'hFF;
            bus_err   <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (wp_block) begin
                            state <= S_RELEASE;
                        end else begin
                            mem_addr  <= req_addr;
                            mem_we    <= !wr_n;
                            mem_wdata <= cpu_dout;
                            mem_req   <= 1'b1;
                            cnt       <= '0;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!mem_we) rdata <= mem_rdata;
                        state   <= S_RELEASE;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        rdata   <= 8'hFF;
                        bus_err <= 1'b1;
                        state   <= S_RELEASE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_RELEASE: begin
                    // Wait for the CPU to end its cycle so one strobe yields one transaction.
                    if (mreq_n || (rd_n && wr_n)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_z80_mem_bridge.sv
// Directed self-checking bench for z80_mem_bridge: instance A uses default parameters,
// instance B uses ADDR_BASE=18'h3FFFF and TIMEOUT=4.
module tb_z80_mem_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
    logic        ack_a = 1'b0, ack_b = 1'b0;
    logic [7:0]  mem_rdata = '0;

    logic [7:0]  cpu_din_a, cpu_din_b, mem_wdata_a, mem_wdata_b;
    logic        cpu_cen_a, cpu_cen_b, mem_req_a, mem_req_b, mem_we_a, mem_we_b;
    logic        bus_err_a, bus_err_b;
    logic [17:0] mem_addr_a, mem_addr_b;

    int n_cmp = 0;
    int n_err = 0;

    // Free-running event counters sampled mid-cycle; tasks take deltas.
    int cen_low_a = 0, req_high_a = 0, req_rise_a = 0;
    int cen_low_b = 0, req_high_b = 0;
    logic req_prev_a = 1'b0;

    always #5 clk = ~clk;

    z80_mem_bridge #(.ADDR_W(18), .ADDR_BASE(0), .TIMEOUT(255)) u_dut_a (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din_a),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .cpu_cen(cpu_cen_a),
        .mem_req(mem_req_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_ack(ack_a), .mem_rdata(mem_rdata), .bus_err(bus_err_a)
    );

    z80_mem_bridge #(.ADDR_W(18), .ADDR_BASE(18'h3FFFF), .TIMEOUT(4)) u_dut_b (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_din(cpu_din_b),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .cpu_cen(cpu_cen_b),
        .mem_req(mem_req_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_ack(ack_b), .mem_rdata(mem_rdata), .bus_err(bus_err_b)
    );

    always @(negedge clk) begin
        if (!cpu_cen_a) cen_low_a++;
        if (mem_req_a) req_high_a++;
        if (mem_req_a && !req_prev_a) req_rise_a++;
        req_prev_a = mem_req_a;
        if (!cpu_cen_b) cen_low_b++;
        if (mem_req_b) req_high_b++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_bus();
        cycle(); cycle();
        reset = 1'b0;
        n_cmp++; if (mem_req_a !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", mem_req_a); end
        n_cmp++; if (mem_we_a !== 1'b0) begin n_err++; $display("FAIL rst_we: got %b want 0", mem_we_a); end
        n_cmp++; if (mem_addr_a !== 18'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", mem_addr_a); end
        n_cmp++; if (mem_wdata_a !== 8'h00) begin n_err++; $display("FAIL rst_wdata: got %h want 00", mem_wdata_a); end
        n_cmp++; if (cpu_din_a !== 8'hFF) begin n_err++; $display("FAIL rst_din: got %h want ff", cpu_din_a); end
        n_cmp++; if (bus_err_a !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus_err_a); end
        n_cmp++; if (cpu_cen_a !== 1'b1) begin n_err++; $display("FAIL rst_cen: got %b want 1", cpu_cen_a); end
    endtask

    task automatic test_read_immediate();
        int c0, r0, h0;
        c0 = cen_low_a; r0 = req_rise_a; h0 = req_high_a;
        cpu_addr = 16'h8000; mreq_n = 1'b0; rd_n = 1'b0;
        #1;
        n_cmp++; if (cpu_cen_a !== 1'b0) begin n_err++; $display("FAIL rd_start_cen: got %b want 0", cpu_cen_a); end
        cycle();
        n_cmp++; if (mem_req_a !== 1'b1) begin n_err++; $display("FAIL rd_req: got %b want 1", mem_req_a); end
        n_cmp++; if (mem_addr_a !== 18'h08000) begin n_err++; $display("FAIL rd_addr: got %h want 08000", mem_addr_a); end
        n_cmp++; if (mem_we_a !== 1'b0) begin n_err++; $display("FAIL rd_we: got %b want 0", mem_we_a); end
        ack_a = 1'b1; mem_rdata = 8'h3C;
        cycle();
        ack_a = 1'b0; mem_rdata = 8'h00;
        n_cmp++; if (cpu_cen_a !== 1'b1) begin n_err++; $display("FAIL rd_resume: got %b want 1", cpu_cen_a); end
        n_cmp++; if (cpu_din_a !== 8'h3C) begin n_err++; $display("FAIL rd_data: got %h want 3c", cpu_din_a); end
        cycle();
        n_cmp++; if (mem_req_a !== 1'b0) begin n_err++; $display("FAIL rd_release_req: got %b want 0", mem_req_a); end
        idle_bus();
        cycle(); cycle();
        n_cmp++; if (cpu_din_a !== 8'h3C) begin n_err++; $display("FAIL rd_hold: got %h want 3c", cpu_din_a); end
        n_cmp++; if (cen_low_a - c0 !== 2) begin n_err++; $display("FAIL rd_stall_cycles: got %0d want 2", cen_low_a - c0); end
        n_cmp++; if (req_rise_a - r0 !== 1) begin n_err++; $display("FAIL rd_req_count: got %0d want 1", req_rise_a - r0); end
        n_cmp++; if (req_high_a - h0 !== 1) begin n_err++; $display("FAIL rd_req_cycles: got %0d want 1", req_high_a - h0); end
    endtask

    task automatic test_write_delayed();
        int c0, h0;
        c0 = cen_low_a; h0 = req_high_a;
        cpu_addr = 16'h5A00; cpu_dout = 8'hA5; mreq_n = 1'b0; wr_n = 1'b0;
        cycle();
        n_cmp++; if (mem_we_a !== 1'b1) begin n_err++; $display("FAIL wr_we: got %b want 1", mem_we_a); end
        n_cmp++; if (mem_wdata_a !== 8'hA5) begin n_err++; $display("FAIL wr_wdata: got %h want a5", mem_wdata_a); end
        n_cmp++; if (mem_addr_a !== 18'h05A00) begin n_err++; $display("FAIL wr_addr: got %h want 05a00", mem_addr_a); end
        cycle(); cycle(); cycle(); cycle();
        n_cmp++; if (mem_req_a !== 1'b1) begin n_err++; $display("FAIL wr_req_held: got %b want 1", mem_req_a); end
        ack_a = 1'b1;
        cycle();
        ack_a = 1'b0;
        n_cmp++; if (mem_req_a !== 1'b0) begin n_err++; $display("FAIL wr_req_drop: got %b want 0", mem_req_a); end
        n_cmp++; if (cpu_din_a !== 8'h3C) begin n_err++; $display("FAIL wr_rdata_kept: got %h want 3c", cpu_din_a); end
        cycle();
        idle_bus();
        cycle(); cycle();
        n_cmp++; if (cen_low_a - c0 !== 6) begin n_err++; $display("FAIL wr_stall_cycles: got %0d want 6", cen_low_a - c0); end
        n_cmp++; if (req_high_a - h0 !== 5) begin n_err++; $display("FAIL wr_req_cycles: got %0d want 5", req_high_a - h0); end
    endtask

    task automatic test_io_read();
        int c0, r0;
        c0 = cen_low_a; r0 = req_rise_a;
        iorq_n = 1'b0; rd_n = 1'b0; mreq_n = 1'b1; cpu_addr = 16'h00FE;
        #1;
        n_cmp++; if (cpu_din_a !== 8'hFF) begin n_err++; $display("FAIL io_din: got %h want ff", cpu_din_a); end
        n_cmp++; if (cpu_cen_a !== 1'b1) begin n_err++; $display("FAIL io_cen: got %b want 1", cpu_cen_a); end
        cycle(); cycle();
        idle_bus();
        #1;
        n_cmp++; if (cpu_din_a !== 8'h3C) begin n_err++; $display("FAIL io_after_din: got %h want 3c", cpu_din_a); end
        cycle();
        n_cmp++; if (req_rise_a - r0 !== 0) begin n_err++; $display("FAIL io_req_count: got %0d want 0", req_rise_a - r0); end
        n_cmp++; if (cen_low_a - c0 !== 0) begin n_err++; $display("FAIL io_stall: got %0d want 0", cen_low_a - c0); end
    endtask

    task automatic test_reset_mid_op();
        cpu_addr = 16'h8001; mreq_n = 1'b0; rd_n = 1'b0;
        cycle();
        n_cmp++; if (mem_req_a !== 1'b1) begin n_err++; $display("FAIL rm_req_up: got %b want 1", mem_req_a); end
        reset = 1'b1;
        cycle();
        n_cmp++; if (mem_req_a !== 1'b0) begin n_err++; $display("FAIL rm_req_drop: got %b want 0", mem_req_a); end
        n_cmp++; if (bus_err_a !== 1'b0) begin n_err++; $display("FAIL rm_err: got %b want 0", bus_err_a); end
        idle_bus();
        reset = 1'b0;
        ack_a = 1'b1; mem_rdata = 8'h99;
        cycle();
        ack_a = 1'b0; mem_rdata = 8'h00;
        cycle();
        n_cmp++; if (cpu_din_a !== 8'hFF) begin n_err++; $display("FAIL rm_late_ack: got %h want ff", cpu_din_a); end
        n_cmp++; if (mem_req_a !== 1'b0) begin n_err++; $display("FAIL rm_req_idle: got %b want 0", mem_req_a); end
        n_cmp++; if (cpu_cen_a !== 1'b1) begin n_err++; $display("FAIL rm_cen: got %b want 1", cpu_cen_a); end
    endtask

    task automatic test_rom_protect();
        int c0, r0;
        c0 = cen_low_a; r0 = req_rise_a;
        cpu_addr = 16'h1234; cpu_dout = 8'h77; mreq_n = 1'b0; wr_n = 1'b0;
        cycle();
`ifdef ROM_WP_EN
        n_cmp++; if (mem_req_a !== 1'b0) begin n_err++; $display("FAIL wp_no_req: got %b want 0", mem_req_a); end
        n_cmp++; if (cpu_cen_a !== 1'b1) begin n_err++; $display("FAIL wp_cen: got %b want 1", cpu_cen_a); end
        cycle();
        idle_bus();
        cycle(); cycle();
        n_cmp++; if (cen_low_a - c0 !== 1) begin n_err++; $display("FAIL wp_stall: got %0d want 1", cen_low_a - c0); end
        n_cmp++; if (req_rise_a - r0 !== 0) begin n_err++; $display("FAIL wp_req_count: got %0d want 0", req_rise_a - r0); end
`else
        n_cmp++; if (mem_req_a !== 1'b1) begin n_err++; $display("FAIL nwp_req: got %b want 1", mem_req_a); end
        n_cmp++; if (mem_addr_a !== 18'h01234) begin n_err++; $display("FAIL nwp_addr: got %h want 01234", mem_addr_a); end
        ack_a = 1'b1;
        cycle();
        ack_a = 1'b0;
        idle_bus();
        cycle(); cycle();
        n_cmp++; if (cen_low_a - c0 !== 2) begin n_err++; $display("FAIL nwp_stall: got %0d want 2", cen_low_a - c0); end
`endif
        n_cmp++; if (bus_err_a !== 1'b0) begin n_err++; $display("FAIL wp_err: got %b want 0", bus_err_a); end
        n_cmp++; if (cpu_din_a !== 8'hFF) begin n_err++; $display("FAIL wp_rdata: got %h want ff", cpu_din_a); end
        // rd_n and wr_n both low: treated as a write
        c0 = cen_low_a;
        cpu_addr = 16'h4000; cpu_dout = 8'h5E; mreq_n = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
        cycle();
        n_cmp++; if (mem_req_a !== 1'b1) begin n_err++; $display("FAIL w4000_req: got %b want 1", mem_req_a); end
        n_cmp++; if (mem_we_a !== 1'b1) begin n_err++; $display("FAIL w4000_we: got %b want 1", mem_we_a); end
        n_cmp++; if (mem_addr_a !== 18'h04000) begin n_err++; $display("FAIL w4000_addr: got %h want 04000", mem_addr_a); end
        n_cmp++; if (mem_wdata_a !== 8'h5E) begin n_err++; $display("FAIL w4000_wdata: got %h want 5e", mem_wdata_a); end
        ack_a = 1'b1; mem_rdata = 8'h11;
        cycle();
        ack_a = 1'b0; mem_rdata = 8'h00;
        idle_bus();
        cycle(); cycle();
        n_cmp++; if (cen_low_a - c0 !== 2) begin n_err++; $display("FAIL w4000_stall: got %0d want 2", cen_low_a - c0); end
        n_cmp++; if (cpu_din_a !== 8'hFF) begin n_err++; $display("FAIL w4000_rdata: got %h want ff", cpu_din_a); end
    endtask

    task automatic test_wrap();
        reset = 1'b1;
        idle_bus();
        cycle(); cycle();
        reset = 1'b0;
        cpu_addr = 16'h0002; mreq_n = 1'b0; rd_n = 1'b0;
        cycle();
        n_cmp++; if (mem_addr_b !== 18'h00001) begin n_err++; $display("FAIL wrap_addr: got %h want 00001", mem_addr_b); end
        n_cmp++; if (mem_req_b !== 1'b1) begin n_err++; $display("FAIL wrap_req: got %b want 1", mem_req_b); end
        ack_b = 1'b1; mem_rdata = 8'h5A;
        cycle();
        ack_b = 1'b0; mem_rdata = 8'h00;
        n_cmp++; if (cpu_din_b !== 8'h5A) begin n_err++; $display("FAIL wrap_din: got %h want 5a", cpu_din_b); end
        idle_bus();
        cycle(); cycle();
    endtask

    task automatic test_timeout();
        int c0, h0;
        c0 = cen_low_b; h0 = req_high_b;
        cpu_addr = 16'hC000; mreq_n = 1'b0; rd_n = 1'b0;
        cycle(); cycle(); cycle(); cycle();
        n_cmp++; if (mem_req_b !== 1'b1) begin n_err++; $display("FAIL to_req_held: got %b want 1", mem_req_b); end
        n_cmp++; if (bus_err_b !== 1'b0) begin n_err++; $display("FAIL to_err_early: got %b want 0", bus_err_b); end
        cycle();
        n_cmp++; if (mem_req_b !== 1'b0) begin n_err++; $display("FAIL to_req_drop: got %b want 0", mem_req_b); end
        n_cmp++; if (bus_err_b !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", bus_err_b); end
        n_cmp++; if (cpu_din_b !== 8'hFF) begin n_err++; $display("FAIL to_din: got %h want ff", cpu_din_b); end
        n_cmp++; if (cpu_cen_b !== 1'b1) begin n_err++; $display("FAIL to_cen: got %b want 1", cpu_cen_b); end
        idle_bus();
        cycle(); cycle(); cycle();
        n_cmp++; if (bus_err_b !== 1'b1) begin n_err++; $display("FAIL to_err_sticky: got %b want 1", bus_err_b); end
        n_cmp++; if (req_high_b - h0 !== 4) begin n_err++; $display("FAIL to_req_cycles: got %0d want 4", req_high_b - h0); end
        n_cmp++; if (cen_low_b - c0 !== 5) begin n_err++; $display("FAIL to_stall: got %0d want 5", cen_low_b - c0); end
    endtask

    initial begin
        test_reset();
        test_read_immediate();
        test_write_delayed();
        test_io_read();
        test_reset_mid_op();
        test_rom_protect();
        test_wrap();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
